pc_unit: RTL and testbench

Parametrised program-counter unit for the MIPS datapath. It holds the current fetch address and selects the next one from sequential, branch, jump, return and exception sources. It also provides stall hold, a circular return-address stack (RAS) for call/return, and an exception PC (EPC) capture register. It feeds the instruction memory address and receives redirect controls from decode/execute.

---
 rtl/pc_unit.sv | 143 ++++++++++++++
 tb/tb_pc_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// Module  : pc_unit
// Brief   : MIPS program counter with stall, circular RAS and EPC capture.
// Revision: 1.0
// ============================================================================
module pc_unit #(
    parameter int              AW           = 32,
    parameter int              DEPTH        = 4,
    parameter logic [AW-1:0]   RESET_VECTOR = '0,
    parameter logic [AW-1:0]   EXC_VECTOR   = AW'(32'h80000180)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall,
    input  logic          branch_taken,
    input  logic [AW-1:0] branch_target,
    input  logic          jump,
    input  logic          call,
    input  logic [AW-1:0] jump_target,
    input  logic          ret,
    input  logic          exc,
    output logic [AW-1:0] pc_o,
    output logic [AW-1:0] pc_plus4,
    output logic [AW-1:0] epc,
    output logic          ras_empty,
    output logic          ras_full,
    output logic          ras_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [CW-1:0] c_CNT_MAX = CW'(DEPTH);
    localparam logic [CW-1:0] c_CNT_ONE = CW'(1);
    localparam logic [PW-1:0] c_PTR_ONE = PW'(1);
    localparam logic [AW-1:0] c_FOUR    = AW'(4);

    logic [AW-1:0] r_pc;
    logic [AW-1:0] r_epc;
    logic [CW-1:0] r_cnt;
    logic [PW-1:0] r_top;
    logic          r_err;
    logic [AW-1:0] r_ras [DEPTH];

    logic [AW-1:0] w_pc_plus4;
    logic          w_empty;
    logic          w_full;
    logic [AW-1:0] w_nxt_pc;
    logic [AW-1:0] w_nxt_epc;
    logic [CW-1:0] w_nxt_cnt;
    logic [PW-1:0] w_nxt_top;
    logic          w_nxt_err;
    logic          w_wr_en;
    logic [PW-1:0] w_wr_idx;

    function automatic logic [AW-1:0] align4(input logic [AW-1:0] a);
        return {a[AW-1:2], 2'b00};
    endfunction

    assign w_pc_plus4 = r_pc + c_FOUR;
    assign w_empty    = (r_cnt == '0);
    assign w_full     = (r_cnt == c_CNT_MAX);

    always_comb begin
        w_nxt_pc  = r_pc;
        w_nxt_epc = r_epc;
        w_nxt_cnt = r_cnt;
        w_nxt_top = r_top;
        w_nxt_err = r_err;
        w_wr_en   = 1'b0;
        w_wr_idx  = r_top;

        if (exc) begin
            w_nxt_pc  = EXC_VECTOR;
            w_nxt_epc = r_pc;
        end else if (!stall) begin
            if (ret) begin
                if (w_empty) begin
                    // Return with nothing to return to is trapped like an exception.
                    w_nxt_pc  = EXC_VECTOR;
                    w_nxt_epc = r_pc;
                    w_nxt_err = 1'b1;
                end else begin
                    w_nxt_pc = align4(r_ras[r_top]);
                    if (call) begin
                        w_wr_en = 1'b1;
                    end else begin
                        w_nxt_top = r_top - c_PTR_ONE;
                        w_nxt_cnt = r_cnt - c_CNT_ONE;
                    end
                end
            end else if (call) begin
                // A push on a full stack silently overwrites the oldest entry.
                w_wr_en   = 1'b1;
                w_wr_idx  = r_top + c_PTR_ONE;
                w_nxt_top = r_top + c_PTR_ONE;
                if (!w_full) begin
                    w_nxt_cnt = r_cnt + c_CNT_ONE;
                end
                w_nxt_pc = align4(jump_target);
            end else if (jump) begin
                w_nxt_pc = align4(jump_target);
            end else if (branch_taken) begin
                w_nxt_pc = align4(branch_target);
            end else begin
                w_nxt_pc = w_pc_plus4;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc  <= RESET_VECTOR;
            r_epc <= '0;
            r_cnt <= '0;
            r_top <= '0;
            r_err <= 1'b0;
        end else begin
            r_pc  <= w_nxt_pc;
            r_epc <= w_nxt_epc;
            r_cnt <= w_nxt_cnt;
            r_top <= w_nxt_top;
            r_err <= w_nxt_err;
        end
    end

    // Entry contents are meaningless while the count is zero, so no reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_ras[w_wr_idx] <= w_pc_plus4;
        end
    end

    assign pc_o      = r_pc;
    assign pc_plus4  = w_pc_plus4;
    assign epc       = r_epc;
    assign ras_empty = w_empty;
    assign ras_full  = w_full;
    assign ras_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_pc_unit
// Brief   : Directed vector-table bench for pc_unit (AW=32, DEPTH=4).
// Revision: 1.0
// ============================================================================
module tb_pc_unit;

    localparam logic [31:0] c_EXC = 32'h80000180;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic        call;
    logic [31:0] jump_target;
    logic        ret;
    logic        exc;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4;
    logic [31:0] epc;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_err;

    int total;
    int bad;

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] bt;
        logic        jmp;
        logic        call;
        logic [31:0] jt;
        logic        ret;
        logic        exc;
        logic [31:0] pc;
        logic [31:0] epc;
        logic        emp;
        logic        full;
        logic        err;
    } vec_t;

    localparam int NV = 35;
    vec_t vec [NV];

    pc_unit #(
        .AW           (32),
        .DEPTH        (4),
        .RESET_VECTOR (32'h0),
        .EXC_VECTOR   (c_EXC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .call          (call),
        .jump_target   (jump_target),
        .ret           (ret),
        .exc           (exc),
        .pc_o          (pc_o),
        .pc_plus4      (pc_plus4),
        .epc           (epc),
        .ras_empty     (ras_empty),
        .ras_full      (ras_full),
        .ras_err       (ras_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic vec_t mk(
        input logic st, input logic br, input logic [31:0] bt,
        input logic jp, input logic cl, input logic [31:0] jt,
        input logic rt, input logic ex,
        input logic [31:0] p, input logic [31:0] e,
        input logic em, input logic fu, input logic er);
        vec_t v;
        v.stall = st; v.br = br; v.bt = bt; v.jmp = jp; v.call = cl;
        v.jt = jt; v.ret = rt; v.exc = ex; v.pc = p; v.epc = e;
        v.emp = em; v.full = fu; v.err = er;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        stall = 0; branch_taken = 0; branch_target = '0; jump = 0;
        call = 0; jump_target = '0; ret = 0; exc = 0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        idle_inputs();

        // idle/branch/stall/exception, then call/ret pairs and priorities
        vec[0]  = mk(0,0,32'h0,   0,0,32'h0,   0,0, 32'h4,      32'h0,   1,0,0);
        vec[1]  = mk(0,0,32'h0,   0,0,32'h0,   0,0, 32'h8,      32'h0,   1,0,0);
        vec[2]  = mk(0,0,32'h0,   0,0,32'h0,   0,0, 32'hC,      32'h0,   1,0,0);
        vec[3]  = mk(0,1,32'h100, 0,0,32'h0,   0,0, 32'h100,    32'h0,   1,0,0);
        vec[4]  = mk(1,1,32'h200, 0,0,32'h0,   0,0, 32'h100,    32'h0,   1,0,0);
        vec[5]  = mk(1,1,32'h200, 0,0,32'h0,   0,1, c_EXC,      32'h100, 1,0,0);
        vec[6]  = mk(0,0,32'h0,   1,0,32'h10,  0,0, 32'h10,     32'h100, 1,0,0);
        vec[7]  = mk(0,0,32'h0,   0,1,32'h400, 0,0, 32'h400,    32'h100, 0,0,0);
        vec[8]  = mk(0,0,32'h0,   0,1,32'h800, 0,0, 32'h800,    32'h100, 0,0,0);
        vec[9]  = mk(0,0,32'h0,   0,0,32'h0,   1,0, 32'h404,    32'h100, 0,0,0);
        vec[10] = mk(0,0,32'h0,   0,0,32'h0,   1,0, 32'h14,     32'h100, 1,0,0);
        vec[11] = mk(0,1,32'h50,  1,0,32'h1003,0,0, 32'h1000,   32'h100, 1,0,0);
        vec[12] = mk(0,1,32'h2002,0,0,32'h0,   0,0, 32'h2000,   32'h100, 1,0,0);
        vec[13] = mk(1,0,32'h0,   0,1,32'h300, 0,0, 32'h2000,   32'h100, 1,0,0);
        vec[14] = mk(1,0,32'h0,   0,0,32'h0,   1,0, 32'h2000,   32'h100, 1,0,0);
        vec[15] = mk(0,0,32'h0,   0,1,32'h300, 1,1, c_EXC,      32'h2000,1,0,0);
        vec[16] = mk(0,0,32'h0,   1,0,32'h0,   0,0, 32'h0,      32'h2000,1,0,0);
        // five nested calls into a 4-deep stack, then five returns
        vec[17] = mk(0,0,32'h0,   0,1,32'h100, 0,0, 32'h100,    32'h2000,0,0,0);
        vec[18] = mk(0,0,32'h0,   0,1,32'h200, 0,0, 32'h200,    32'h2000,0,0,0);
        vec[19] = mk(0,0,32'h0,   0,1,32'h300, 0,0, 32'h300,    32'h2000,0,0,0);
        vec[20] = mk(0,0,32'h0,   0,1,32'h400, 0,0, 32'h400,    32'h2000,0,1,0);
        vec[21] = mk(0,0,32'h0,   0,1,32'h500, 0,0, 32'h500,    32'h2000,0,1,0);
        vec[22] = mk(0,0,32'h0,   0,0,32'h0,   1,0, 32'h404,    32'h2000,0,0,0);
        vec[23] = mk(0,0,32'h0,   0,0,32'h0,   1,0, 32'h304,    32'h2000,0,0,0);
        vec[24] = mk(0,0,32'h0,   0,0,32'h0,   1,0, 32'h204,    32'h2000,0,0,0);
        vec[25] = mk(0,0,32'h0,   0,0,32'h0,   1,0, 32'h104,    32'h2000,1,0,0);
        vec[26] = mk(0,0,32'h0,   0,0,32'h0,   1,0, c_EXC,      32'h104, 1,0,1);
        vec[27] = mk(0,0,32'h0,   0,0,32'h0,   0,0, c_EXC+32'h4,32'h104, 1,0,1);
        vec[28] = mk(1,0,32'h0,   0,0,32'h0,   0,0, c_EXC+32'h4,32'h104, 1,0,1);
        // simultaneous call+ret replaces the top entry
        vec[29] = mk(0,0,32'h0,   1,0,32'h40,  0,0, 32'h40,     32'h104, 1,0,1);
        vec[30] = mk(0,0,32'h0,   0,1,32'h80,  0,0, 32'h80,     32'h104, 0,0,1);
        vec[31] = mk(0,0,32'h0,   0,1,32'h999, 1,0, 32'h44,     32'h104, 0,0,1);
        vec[32] = mk(0,0,32'h0,   0,0,32'h0,   1,0, 32'h84,     32'h104, 1,0,1);
        vec[33] = mk(0,0,32'h0,   1,0,32'hFFFFFFFC,0,0, 32'hFFFFFFFC,32'h104,1,0,1);
        vec[34] = mk(0,0,32'h0,   0,0,32'h0,   0,0, 32'h0,      32'h104, 1,0,1);

        repeat (2) @(posedge clk);
        #1;
        chk("reset pc",    pc_o,      32'h0);
        chk("reset pc+4",  pc_plus4,  32'h4);
        chk("reset epc",   epc,       32'h0);
        chk("reset empty", {31'd0, ras_empty}, 32'd1);
        chk("reset full",  {31'd0, ras_full},  32'd0);
        chk("reset err",   {31'd0, ras_err},   32'd0);
        reset = 1'b1;

        for (int i = 0; i < NV; i++) begin
            stall         = vec[i].stall;
            branch_taken  = vec[i].br;
            branch_target = vec[i].bt;
            jump          = vec[i].jmp;
            call          = vec[i].call;
            jump_target   = vec[i].jt;
            ret           = vec[i].ret;
            exc           = vec[i].exc;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d pc", i),    pc_o,     vec[i].pc);
            chk($sformatf("v%0d pc+4", i),  pc_plus4, vec[i].pc + 32'h4);
            chk($sformatf("v%0d epc", i),   epc,      vec[i].epc);
            chk($sformatf("v%0d empty", i), {31'd0, ras_empty}, {31'd0, vec[i].emp});
            chk($sformatf("v%0d full", i),  {31'd0, ras_full},  {31'd0, vec[i].full});
            chk($sformatf("v%0d err", i),   {31'd0, ras_err},   {31'd0, vec[i].err});
        end

        // asynchronous reset in the middle of a call sequence
        idle_inputs();
        call = 1; jump_target = 32'h600;
        @(posedge clk);
        #1;
        chk("mid call pc",    pc_o, 32'h600);
        chk("mid call empty", {31'd0, ras_empty}, 32'd0);
        idle_inputs();
        #3 reset = 1'b0;
        #1;
        chk("async rst pc",    pc_o, 32'h0);
        chk("async rst epc",   epc,  32'h0);
        chk("async rst empty", {31'd0, ras_empty}, 32'd1);
        chk("async rst err",   {31'd0, ras_err},   32'd0);
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        chk("post rst pc", pc_o, 32'h4);
        ret = 1;
        @(posedge clk);
        #1;
        chk("post rst ret pc",  pc_o, c_EXC);
        chk("post rst ret epc", epc,  32'h4);
        chk("post rst ret err", {31'd0, ras_err}, 32'd1);
        idle_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
